// File: rtl/isu_issue_buf_if.sv
// Handshake and data bundle between decode, the issue buffer and execute.
//   Decode side : in_valid[1:0] (bit0 older), in_rd/in_rj/in_rk (5b per slot),
//                 in_is_mul, in_payload (PAY_W per slot), in_ready back.
//   Execute side: iss_valid[1:0], iss_rd/iss_rj/iss_rk, iss_is_mul,
//                 iss_payload per lane, exu_ready back.
//   Debug       : count, occupied entries.
// The slave modport is the buffer's view; the master modport drives the
// decode/execute side (decode + execute models in a bench).
interface isu_issue_buf_if #(
  parameter int DEPTH = 8,
  parameter int PAY_W = 64
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]            in_valid;
  logic [1:0][4:0]       in_rd;
  logic [1:0][4:0]       in_rj;
  logic [1:0][4:0]       in_rk;
  logic [1:0]            in_is_mul;
  logic [1:0][PAY_W-1:0] in_payload;
  logic                  in_ready;

  logic                  exu_ready;
  logic [1:0]            iss_valid;
  logic [1:0][4:0]       iss_rd;
  logic [1:0][4:0]       iss_rj;
  logic [1:0][4:0]       iss_rk;
  logic [1:0]            iss_is_mul;
  logic [1:0][PAY_W-1:0] iss_payload;

  logic [CW-1:0]         count;

  modport slave (
    input  in_valid, in_rd, in_rj, in_rk, in_is_mul, in_payload, exu_ready,
    output in_ready, iss_valid, iss_rd, iss_rj, iss_rk, iss_is_mul,
           iss_payload, count
  );

  modport master (
    output in_valid, in_rd, in_rj, in_rk, in_is_mul, in_payload, exu_ready,
    input  in_ready, iss_valid, iss_rd, iss_rj, iss_rk, iss_is_mul,
           iss_payload, count
  );
endinterface

// File: rtl/isu_issue_buf.sv
// In-order dual-issue instruction buffer between decode and execute.
// Up to two micro-ops are written per cycle into a circular buffer; up to two
// are presented per cycle to execute lanes 0/1 (head, head+1). Lane 1 issues
// only if head+1 does not read head's destination and the two are not both
// multiplies. flush empties the buffer and blocks enqueue/issue that cycle.
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset of head/tail/count
//   flush  discard all entries and this cycle's enqueue
//   bus    isu_issue_buf_if.slave: decode inputs, in_ready, issue lanes,
//          exu_ready, count
module isu_issue_buf #(
  parameter int DEPTH = 8,
  parameter int PAY_W = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  isu_issue_buf_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]       rd;
    logic [4:0]       rj;
    logic [4:0]       rk;
    logic             is_mul;
    logic [PAY_W-1:0] payload;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   head1;
  logic [AW-1:0]   tail1;
  entry_t          e0;
  entry_t          e1;
  entry_t          slot0;
  entry_t          slot1;
  logic            ready;
  logic [1:0]      n_enq;
  logic [1:0]      n_deq;
  logic            c0;
  logic            c1;
  logic            raw;
  logic            pair_ok;
  logic [1:0]      valid;

  function automatic logic [1:0] enq_count(input logic rdy, input logic [1:0] v);
    // 2'b10 is illegal and must not enqueue anything
    if (!rdy)          return 2'd0;
    else if (v == 2'b11) return 2'd2;
    else if (v == 2'b01) return 2'd1;
    else               return 2'd0;
  endfunction

  // Enqueue side: ready depends only on registered occupancy and flush
  assign head1 = head + AW'(1);
  assign tail1 = tail + AW'(1);
  assign ready = (cnt <= CW'(DEPTH - 2)) && !flush;
  assign n_enq = enq_count(ready, bus.in_valid);

  assign slot0 = '{rd: bus.in_rd[0], rj: bus.in_rj[0], rk: bus.in_rk[0],
                   is_mul: bus.in_is_mul[0], payload: bus.in_payload[0]};
  assign slot1 = '{rd: bus.in_rd[1], rj: bus.in_rj[1], rk: bus.in_rk[1],
                   is_mul: bus.in_is_mul[1], payload: bus.in_payload[1]};

  // Issue side: combinational from stored entries, no bypass from inputs
  assign e0 = mem[head];
  assign e1 = mem[head1];
  assign c0 = (cnt >= CW'(1)) && !flush;
  assign c1 = (cnt >= CW'(2)) && !flush;

  // rd == 0 is "no write", so it can never create a RAW dependency
  assign raw     = (e0.rd != 5'd0) && ((e1.rj == e0.rd) || (e1.rk == e0.rd));
  assign pair_ok = !raw && !(e0.is_mul && e1.is_mul);
  assign valid   = {c0 && c1 && pair_ok, c0};

  // Execute takes the whole group or nothing
  assign n_deq = bus.exu_ready ? ({1'b0, valid[0]} + {1'b0, valid[1]}) : 2'd0;

  assign bus.in_ready       = ready;
  assign bus.iss_valid      = valid;
  assign bus.iss_rd         = {e1.rd, e0.rd};
  assign bus.iss_rj         = {e1.rj, e0.rj};
  assign bus.iss_rk         = {e1.rk, e0.rk};
  assign bus.iss_is_mul     = {e1.is_mul, e0.is_mul};
  assign bus.iss_payload    = {e1.payload, e0.payload};
  assign bus.count          = cnt;

  // Pointer / occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + AW'(n_deq);
      tail <= tail + AW'(n_enq);
      cnt  <= cnt + CW'(n_enq) - CW'(n_deq);
    end
  end

  // Entry storage: data only, never reset; n_enq is already zero under flush
  always_ff @(posedge clk) begin
    if (n_enq != 2'd0) mem[tail]  <= slot0;
    if (n_enq == 2'd2) mem[tail1] <= slot1;
  end

endmodule

// File: tb/tb_isu_issue_buf.sv
module tb_isu_issue_buf;

  localparam int DEPTH = 8;
  localparam int PAY_W = 64;

  typedef struct {
    logic [4:0]  rd;
    logic [4:0]  rj;
    logic [4:0]  rk;
    logic        mul;
    logic [63:0] pay;
  } ent_t;

  logic clk;
  logic rst_n;
  logic flush;

  isu_issue_buf_if #(.DEPTH(DEPTH), .PAY_W(PAY_W)) bus ();

  isu_issue_buf #(.DEPTH(DEPTH), .PAY_W(PAY_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  ent_t q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic ent_t mk(input int rd, input int rj, input int rk, input bit mul);
    ent_t e;
    e.rd  = 5'(rd);
    e.rj  = 5'(rj);
    e.rk  = 5'(rk);
    e.mul = mul;
    e.pay = {$urandom, $urandom};
    return e;
  endfunction

  function automatic bit can_pair(input ent_t a, input ent_t b);
    bit dep;
    dep = (a.rd != 0) && (b.rj == a.rd || b.rk == a.rd);
    return !dep && !(a.mul && b.mul);
  endfunction

  function automatic ent_t slot(input int i);
    ent_t e;
    e.rd  = bus.in_rd[i];
    e.rj  = bus.in_rj[i];
    e.rk  = bus.in_rk[i];
    e.mul = bus.in_is_mul[i];
    e.pay = bus.in_payload[i];
    return e;
  endfunction

  // Expected issue group from the queue model
  function automatic logic [1:0] exp_valid();
    logic v0, v1;
    v0 = (q.size() >= 1) && !flush;
    v1 = v0 && (q.size() >= 2) && can_pair(q[0], q[1]);
    return {v1, v0};
  endfunction

  // Model update at each active edge (and immediately on reset)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else begin
      logic [1:0] v;
      bit acc;
      int nd;
      v   = exp_valid();
      acc = (DEPTH - q.size()) >= 2;
      nd  = bus.exu_ready ? (int'(v[0]) + int'(v[1])) : 0;
      for (int i = 0; i < nd; i++) void'(q.pop_front());
      if (acc && bus.in_valid == 2'b11) begin
        q.push_back(slot(0));
        q.push_back(slot(1));
      end else if (acc && bus.in_valid == 2'b01) begin
        q.push_back(slot(0));
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      logic [1:0] v;
      v = exp_valid();
      chk("m_count", 64'(bus.count), 64'(q.size()));
      chk("m_in_ready", 64'(bus.in_ready), 64'(((DEPTH - q.size()) >= 2) && !flush));
      chk("m_iss_valid", 64'(bus.iss_valid), 64'(v));
      if (v[0]) begin
        chk("m_l0_fields", 64'({bus.iss_rd[0], bus.iss_rj[0], bus.iss_rk[0], bus.iss_is_mul[0]}),
            64'({q[0].rd, q[0].rj, q[0].rk, q[0].mul}));
        chk("m_l0_pay", bus.iss_payload[0], q[0].pay);
      end
      if (v[1]) begin
        chk("m_l1_fields", 64'({bus.iss_rd[1], bus.iss_rj[1], bus.iss_rk[1], bus.iss_is_mul[1]}),
            64'({q[1].rd, q[1].rj, q[1].rk, q[1].mul}));
        chk("m_l1_pay", bus.iss_payload[1], q[1].pay);
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) assert (bus.in_valid != 2'b10)
      else $error("FAIL illegal_in_valid: got 2'b10 expected not 2'b10");
  end

  task automatic put(input bit fl, input logic [1:0] v, input ent_t s0, input ent_t s1,
                     input bit ex);
    flush             = fl;
    bus.in_valid      = v;
    bus.in_rd         = {s1.rd, s0.rd};
    bus.in_rj         = {s1.rj, s0.rj};
    bus.in_rk         = {s1.rk, s0.rk};
    bus.in_is_mul     = {s1.mul, s0.mul};
    bus.in_payload    = {s1.pay, s0.pay};
    bus.exu_ready     = ex;
  endtask

  // One cycle: inputs applied just after the falling edge, outputs settled 3 later
  task automatic cyc(input bit fl, input logic [1:0] v, input ent_t s0, input ent_t s1,
                     input bit ex);
    @(negedge clk);
    put(fl, v, s0, s1, ex);
    #3;
  endtask

  task automatic idle(input bit ex);
    cyc(1'b0, 2'b00, mk(0, 0, 0, 0), mk(0, 0, 0, 0), ex);
  endtask

  initial begin
    rst_n = 1'b0;
    put(1'b0, 2'b00, mk(0, 0, 0, 0), mk(0, 0, 0, 0), 1'b0);
    repeat (2) @(negedge clk);
    #3;
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_iss_valid", 64'(bus.iss_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst_n = 1'b1;

    // Reset then fill
    cyc(1'b0, 2'b11, mk(1, 2, 3, 0), mk(4, 5, 6, 0), 1'b0);
    chk("fill_ready0", 64'(bus.in_ready), 64'd1);
    idle(1'b0);
    chk("fill_count", 64'(bus.count), 64'd2);
    chk("fill_model_size", 64'(q.size()), 64'd2);
    chk("fill_valid", 64'(bus.iss_valid), 64'b11);
    chk("fill_l0", 64'({bus.iss_rd[0], bus.iss_rj[0], bus.iss_rk[0]}), 64'({5'd1, 5'd2, 5'd3}));
    chk("fill_l1", 64'({bus.iss_rd[1], bus.iss_rj[1], bus.iss_rk[1]}), 64'({5'd4, 5'd5, 5'd6}));
    chk("fill_ready", 64'(bus.in_ready), 64'd1);
    idle(1'b1);
    idle(1'b0);
    chk("fill_drained", 64'(bus.count), 64'd0);

    // RAW split, then rd=0 pairs
    cyc(1'b0, 2'b11, mk(7, 1, 2, 0), mk(3, 7, 0, 0), 1'b0);
    idle(1'b1);
    chk("raw_valid", 64'(bus.iss_valid), 64'b01);
    chk("raw_l0", 64'(bus.iss_rd[0]), 64'd7);
    idle(1'b1);
    chk("raw_next_valid", 64'(bus.iss_valid), 64'b01);
    chk("raw_next_l0", 64'(bus.iss_rd[0]), 64'd3);
    idle(1'b0);
    chk("raw_empty", 64'(bus.iss_valid), 64'd0);
    cyc(1'b0, 2'b11, mk(0, 1, 2, 0), mk(5, 0, 0, 0), 1'b0);
    idle(1'b1);
    chk("rd0_valid", 64'(bus.iss_valid), 64'b11);

    // Double multiply issues one per cycle
    cyc(1'b0, 2'b11, mk(1, 2, 3, 1), mk(4, 5, 6, 1), 1'b0);
    idle(1'b1);
    chk("mul_valid0", 64'(bus.iss_valid), 64'b01);
    idle(1'b1);
    chk("mul_valid1", 64'(bus.iss_valid), 64'b01);
    chk("mul_l0", 64'(bus.iss_rd[0]), 64'd4);
    idle(1'b0);
    chk("mul_empty", 64'(bus.count), 64'd0);

    // Offset head/tail to 1 so the last drained pair straddles index 7/0
    cyc(1'b0, 2'b01, mk(0, 0, 0, 0), mk(0, 0, 0, 0), 1'b0);
    idle(1'b1);
    for (int i = 0; i < 4; i++)
      cyc(1'b0, 2'b11, mk(10 + 2 * i, 0, 0, 0), mk(11 + 2 * i, 0, 0, 0), 1'b0);
    chk("full_count6", 64'(bus.count), 64'd6);
    chk("full_ready6", 64'(bus.in_ready), 64'd1);
    idle(1'b0);
    chk("full_count8", 64'(bus.count), 64'd8);
    chk("full_ready8", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, (i == 3) ? 2'b11 : 2'b00, mk(30, 0, 0, 0), mk(31, 0, 0, 0), 1'b1);
      chk("wrap_valid", 64'(bus.iss_valid), 64'b11);
      chk("wrap_l0", 64'(bus.iss_rd[0]), 64'(10 + 2 * i));
      chk("wrap_l1", 64'(bus.iss_rd[1]), 64'(11 + 2 * i));
    end
    idle(1'b1);
    chk("refill_count", 64'(bus.count), 64'd2);
    chk("refill_l0", 64'(bus.iss_rd[0]), 64'd30);
    chk("refill_l1", 64'(bus.iss_rd[1]), 64'd31);

    // Count 7 blocks a pair
    cyc(1'b0, 2'b01, mk(1, 0, 0, 0), mk(0, 0, 0, 0), 1'b0);
    repeat (3) cyc(1'b0, 2'b11, mk(0, 0, 0, 0), mk(0, 0, 0, 0), 1'b0);
    cyc(1'b0, 2'b11, mk(9, 9, 9, 0), mk(9, 9, 9, 0), 1'b0);
    chk("seven_count", 64'(bus.count), 64'd7);
    chk("seven_ready", 64'(bus.in_ready), 64'd0);
    idle(1'b0);
    chk("seven_dropped", 64'(bus.count), 64'd7);
    repeat (4) idle(1'b1);
    idle(1'b0);
    chk("seven_drained", 64'(bus.count), 64'd0);

    // Flush collides with enqueue and issue
    cyc(1'b0, 2'b11, mk(1, 0, 0, 0), mk(2, 0, 0, 0), 1'b0);
    cyc(1'b0, 2'b11, mk(3, 0, 0, 0), mk(4, 0, 0, 0), 1'b0);
    cyc(1'b0, 2'b01, mk(5, 0, 0, 0), mk(0, 0, 0, 0), 1'b0);
    cyc(1'b1, 2'b11, mk(6, 0, 0, 0), mk(7, 0, 0, 0), 1'b1);
    chk("flush_count5", 64'(bus.count), 64'd5);
    chk("flush_valid", 64'(bus.iss_valid), 64'd0);
    chk("flush_ready", 64'(bus.in_ready), 64'd0);
    idle(1'b0);
    chk("flush_count0", 64'(bus.count), 64'd0);
    chk("flush_after_valid", 64'(bus.iss_valid), 64'd0);

    // Asynchronous reset between edges
    cyc(1'b0, 2'b11, mk(1, 0, 0, 0), mk(2, 0, 0, 0), 1'b0);
    cyc(1'b0, 2'b01, mk(3, 0, 0, 0), mk(0, 0, 0, 0), 1'b0);
    idle(1'b0);
    chk("arst_count3", 64'(bus.count), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_count", 64'(bus.count), 64'd0);
    chk("arst_valid", 64'(bus.iss_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic
    repeat (3000) begin
      int r;
      logic [1:0] v;
      r = $urandom_range(0, 2);
      v = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      cyc($urandom_range(0, 31) == 0, v,
          mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2) == 0),
          mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2) == 0),
          $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    #5;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
